// File: rtl/pe_seq_ctrl_if.sv
// Command, buffer-read, PE and output-write signals of one PE lane.
// The master side is the host/datapath, the slave side is the sequencer.
interface pe_seq_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
);
  logic              start;
  logic [LEN_W-1:0]  vec_len;
  logic [LEN_W-1:0]  row_num;
  logic [ADDR_W-1:0] neuron_base;
  logic [ADDR_W-1:0] weight_base;
  logic [ADDR_W-1:0] out_base;
  logic              busy;
  logic              done;
  logic              neuron_rd_en;
  logic              weight_rd_en;
  logic [ADDR_W-1:0] neuron_rd_addr;
  logic [ADDR_W-1:0] weight_rd_addr;
  logic              pe_vld_i;
  logic [1:0]        pe_ctl;
  logic              pe_vld_o;
  logic [31:0]       pe_result;
  logic              out_wr_en;
  logic [ADDR_W-1:0] out_wr_addr;
  logic [31:0]       out_wr_data;

  modport master (
    output start, vec_len, row_num,
    output neuron_base, weight_base, out_base,
    output pe_vld_o, pe_result,
    input  busy, done,
    input  neuron_rd_en, weight_rd_en,
    input  neuron_rd_addr, weight_rd_addr,
    input  pe_vld_i, pe_ctl,
    input  out_wr_en, out_wr_addr, out_wr_data
  );

  modport slave (
    input  start, vec_len, row_num,
    input  neuron_base, weight_base, out_base,
    input  pe_vld_o, pe_result,
    output busy, done,
    output neuron_rd_en, weight_rd_en,
    output neuron_rd_addr, weight_rd_addr,
    output pe_vld_i, pe_ctl,
    output out_wr_en, out_wr_addr, out_wr_data
  );
endinterface

// File: rtl/pe_seq_ctrl.sv
// Sequencer for one parallel_pe lane: streams neuron/weight chunks
// into the PE and writes each finished row sum to the output buffer.
module pe_seq_ctrl #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input logic        clk,
  input logic        rst,
  pe_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  rows_q;
  logic [LEN_W-1:0]  k;
  logic [LEN_W-1:0]  r;
  logic [LEN_W-1:0]  w;
  logic [ADDR_W-1:0] nbase_q;
  logic [ADDR_W-1:0] wbase_q;
  logic [ADDR_W-1:0] obase_q;
  logic [ADDR_W-1:0] p;
  logic              vld_q;
  logic [1:0]        ctl_q;

  logic zero;
  logic go;
  logic run;
  logic busy;
  logic k_last;
  logic r_last;
  logic wr;

  assign zero   = (bus.vec_len == '0) || (bus.row_num == '0);
  assign go     = (state == IDLE) && bus.start && !zero;
  assign run    = (state == RUN);
  assign busy   = run || (state == DRAIN);
  assign k_last = (k == len_q - LEN_W'(1));
  assign r_last = (r == rows_q - LEN_W'(1));
  assign wr     = bus.pe_vld_o && busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.start) state_nx = zero ? DONE : RUN;
      end
      RUN: begin
        if (k_last && r_last) state_nx = DRAIN;
      end
      DRAIN: begin
        // last write may land in this very cycle
        if (w + LEN_W'(wr) == rows_q) state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      rows_q  <= '0;
      nbase_q <= '0;
      wbase_q <= '0;
      obase_q <= '0;
      k       <= '0;
      r       <= '0;
      w       <= '0;
      p       <= '0;
      vld_q   <= 1'b0;
      ctl_q   <= 2'b00;
    end else begin
      if (go) begin
        len_q   <= bus.vec_len;
        rows_q  <= bus.row_num;
        nbase_q <= bus.neuron_base;
        wbase_q <= bus.weight_base;
        obase_q <= bus.out_base;
        k       <= '0;
        r       <= '0;
        w       <= '0;
        p       <= '0;
      end
      if (run) begin
        p <= p + ADDR_W'(1);
        if (k_last) begin
          k <= '0;
          r <= r + LEN_W'(1);
        end else begin
          k <= k + LEN_W'(1);
        end
      end
      if (wr) w <= w + LEN_W'(1);
      // one stage to line up with the buffer read latency
      vld_q <= run;
      ctl_q <= run ? {k_last, k == '0} : 2'b00;
    end
  end

  assign bus.busy           = busy;
  assign bus.done           = (state == DONE);
  assign bus.neuron_rd_en   = run;
  assign bus.weight_rd_en   = run;
  assign bus.neuron_rd_addr = run ? nbase_q + ADDR_W'(k) : '0;
  assign bus.weight_rd_addr = run ? wbase_q + p : '0;
  assign bus.pe_vld_i       = vld_q;
  assign bus.pe_ctl         = ctl_q;
  assign bus.out_wr_en      = wr;
  assign bus.out_wr_addr    = obase_q + ADDR_W'(w);
  assign bus.out_wr_data    = bus.pe_result;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Bench for pe_seq_ctrl: buffer/PE model plus cycle-tagged scoreboard
// of expected reads, PE controls and output writes.
module tb_pe_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pe_seq_ctrl_if #(.ADDR_W(8), .LEN_W(8)) bus ();

  pe_seq_ctrl #(.ADDR_W(8), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] nval(logic [7:0] a);
    return 32'(a) + 32'd1;
  endfunction

  function automatic logic [31:0] wval(logic [7:0] a);
    return 32'(a) + 32'd5;
  endfunction

  // buffers with 1-cycle read latency, PE with 1-cycle output latency
  logic [31:0] nd = '0;
  logic [31:0] wd = '0;
  logic [31:0] acc = '0;
  logic        pv = 1'b0;
  logic [31:0] res = 32'h1234_5678;
  wire  [31:0] pe_sum = (bus.pe_ctl[0] ? 32'd0 : acc) + nd * wd;

  assign bus.pe_vld_o  = pv;
  assign bus.pe_result = res;

  always @(posedge clk) begin
    if (bus.neuron_rd_en) nd <= nval(bus.neuron_rd_addr);
    if (bus.weight_rd_en) wd <= wval(bus.weight_rd_addr);
    pv <= 1'b0;
    if (bus.pe_vld_i) begin
      acc <= pe_sum;
      if (bus.pe_ctl[1]) begin
        pv  <= 1'b1;
        res <= pe_sum;
      end
    end
  end

  logic [63:0] rd_q[$];
  logic [63:0] ctl_q[$];
  logic [63:0] wr_q[$];

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] cc;
    logic        e;
    logic [63:0] ent;
    cc = cyc[15:0];
    if (!rst) begin
      e = rd_q.size() != 0 && rd_q[0][31:16] == cc;
      if (e || bus.neuron_rd_en || bus.weight_rd_en) begin
        check("rd_en", {bus.neuron_rd_en, bus.weight_rd_en}, {e, e});
        if (e) begin
          ent = rd_q.pop_front();
          check("rd_addr", {cc, bus.neuron_rd_addr, bus.weight_rd_addr}, ent);
        end
      end
      e = ctl_q.size() != 0 && ctl_q[0][17:2] == cc;
      if (e || bus.pe_vld_i) begin
        check("pe_vld_i", bus.pe_vld_i, e);
        if (e) begin
          ent = ctl_q.pop_front();
          check("pe_ctl", {cc, bus.pe_ctl}, ent);
        end
      end
      e = wr_q.size() != 0 && wr_q[0][55:40] == cc;
      if (e || bus.out_wr_en) begin
        check("wr_en", bus.out_wr_en, e);
        if (e) begin
          ent = wr_q.pop_front();
          check("wr", {cc, bus.out_wr_addr, bus.out_wr_data}, ent);
        end
      end
    end
  end

  task automatic start_job(input int len, input int rows,
                           input logic [7:0] nb, input logic [7:0] wb,
                           input logic [7:0] ob);
    int          t0;
    int          n;
    int          k;
    int          r;
    logic [31:0] s;
    @(posedge clk);
    #1;
    t0 = cyc;
    n  = len * rows;
    bus.vec_len     = 8'(len);
    bus.row_num     = 8'(rows);
    bus.neuron_base = nb;
    bus.weight_base = wb;
    bus.out_base    = ob;
    bus.start       = 1'b1;
    s = '0;
    for (int i = 0; i < n; i++) begin
      k = i % len;
      r = i / len;
      rd_q.push_back({32'd0, 16'(t0 + 1 + i), 8'(nb + 8'(k)), 8'(wb + 8'(i))});
      ctl_q.push_back({46'd0, 16'(t0 + 2 + i), k == len - 1, k == 0});
      s = (k == 0 ? 32'd0 : s) + nval(8'(nb + 8'(k))) * wval(8'(wb + 8'(i)));
      if (k == len - 1)
        wr_q.push_back({8'd0, 16'(t0 + 3 + i), 8'(ob + 8'(r)), s});
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // called in cycle 1 of a job; n chunks total, optional stray start
  task automatic wait_done(input int n, input int restart);
    int dc;
    dc = (n == 0) ? 1 : n + 3;
    for (int c = 1; c <= dc + 1; c++) begin
      @(negedge clk);
      check($sformatf("busy_c%0d", c), bus.busy, n != 0 && c < dc);
      check($sformatf("done_c%0d", c), bus.done, c == dc);
      @(posedge clk);
      #1;
      bus.start = (c + 1 == restart);
    end
    bus.start = 1'b0;
    check("rd_left", rd_q.size(), 0);
    check("ctl_left", ctl_q.size(), 0);
    check("wr_left", wr_q.size(), 0);
  endtask

  task automatic check_quiet(string tag);
    check({tag, "_ctl"},
          {bus.busy, bus.done, bus.neuron_rd_en, bus.weight_rd_en,
           bus.pe_vld_i, bus.pe_ctl, bus.out_wr_en}, 0);
    check({tag, "_addr"},
          {bus.neuron_rd_addr, bus.weight_rd_addr, bus.out_wr_addr}, 0);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.vec_len     = '0;
    bus.row_num     = '0;
    bus.neuron_base = '0;
    bus.weight_base = '0;
    bus.out_base    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("rst");
    check("rst_data", bus.out_wr_data, 32'h1234_5678);
    #1;
    rst = 1'b0;

    start_job(1, 1, 8'h00, 8'h00, 8'h00);
    wait_done(1, 0);

    start_job(3, 2, 8'h10, 8'h20, 8'h40);
    wait_done(6, 3);
    repeat (3) begin
      @(negedge clk);
      check("idle_busy", bus.busy, 0);
    end

    start_job(0, 4, 8'h10, 8'h20, 8'h40);
    wait_done(0, 0);
    start_job(2, 2, 8'h05, 8'h07, 8'h09);
    wait_done(4, 0);

    start_job(3, 2, 8'h10, 8'h20, 8'h40);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    rd_q.delete();
    ctl_q.delete();
    wr_q.delete();
    @(negedge clk);
    check_quiet("abort");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    start_job(3, 2, 8'h10, 8'h20, 8'h40);
    wait_done(6, 0);

    start_job(4, 1, 8'hFF, 8'hFE, 8'h80);
    wait_done(4, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_seq_ctrl.md
# pe_seq_ctrl

Sequencer for one `parallel_pe` lane computing a matrix-vector product.
- Reads 512-bit neuron and weight chunks from single-port buffers with 1-cycle read latency, one chunk per cycle.
- Drives the PE's `vld_i`/`ctl` aligned with the returned data.
- Writes each finished 32-bit partial sum from the PE into the output buffer.
- Sits between the top-level command interface and the PE/buffer datapath; buffer read data connects directly to the PE `neuron`/`weight` inputs.

## Interface
Parameters:
- ADDR_W, 8, width of all buffer addresses
- LEN_W, 8, width of vec_len / row_num

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle command pulse, sampled only in IDLE
- vec_len  in  LEN_W  512-bit chunks per output row
- row_num  in  LEN_W  number of output rows
- neuron_base / weight_base / out_base  in  ADDR_W each  buffer base addresses
- busy  out  1  high in RUN and DRAIN
- done  out  1  single-cycle completion pulse
- neuron_rd_en, weight_rd_en  out  1  buffer read strobes (always asserted together)
- neuron_rd_addr, weight_rd_addr  out  ADDR_W  read addresses
- pe_vld_i  out  1  to PE `vld_i`
- pe_ctl  out  2  to PE `ctl`: [0] = first chunk of row, [1] = last chunk of row
- pe_vld_o  in  1  from PE `vld_o`
- pe_result  in  32  from PE `result`
- out_wr_en  out  1  output buffer write strobe
- out_wr_addr  out  ADDR_W  output buffer write address
- out_wr_data  out  32  output buffer write data

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN: on start with vec_len != 0 and row_num != 0. Latches vec_len, row_num and all three bases; clears counters k (chunk), r (row), w (writes).
- IDLE -> DONE: on start with vec_len == 0 or row_num == 0. No reads, no writes.
- RUN, each cycle:
  - Assert both rd_en.
  - neuron_rd_addr = neuron_base + k; the neuron vector is re-read for every row.
  - weight_rd_addr = weight_base + running pointer p; p starts at 0 and increments on every issue, i.e. p = r*vec_len + k.
  - k wraps at vec_len-1 and r increments on wrap.
  - After issuing k = vec_len-1 of r = row_num-1 -> DRAIN.
- DRAIN: no reads. Once w reaches row_num -> DONE. This may happen in the same cycle as the final write.
- DONE: done = 1 for one cycle -> IDLE.
- pe_vld_i and pe_ctl are rd_en and {k==vec_len-1, k==0} registered by one stage. They align with buffer data. For vec_len = 1, pe_ctl = 2'b11.
- Output write path is combinational from the PE:
  - out_wr_en = pe_vld_o & busy.
  - out_wr_data = pe_result.
  - out_wr_addr = out_base + w.
  - w increments on each write.
- pe_vld_o outside busy is ignored: no write, w unchanged.
- start while busy or in DONE is ignored.
- Address arithmetic is modulo 2^ADDR_W and wraps silently. Counters are LEN_W bits; the product vec_len*row_num does not need to fit.
- Reset:
  - rst asserted at any time, including mid-RUN, forces IDLE immediately.
  - All outputs go to 0, all counters clear, and the pipeline stage clears.
  - The PE's own reset is separate. Results still in flight from the aborted job are dropped because busy = 0.

## Timing
- Reset values: busy, done, rd_en, rd_addr, pe_vld_i, pe_ctl and out_wr_en are all 0; out_wr_addr = 0; out_wr_data follows pe_result.
- Let start be sampled high at the end of cycle 0:
  - busy and first rd_en in cycle 1.
  - Issue i (0-based) in cycle 1+i; pe_vld_i in cycle 2+i.
  - PE vld_o, and therefore out_wr_en, in cycle 3+i for a last-chunk issue.
- With N = vec_len*row_num: last issue at cycle N, last write at cycle N+2, busy low and done high in cycle N+3.
- Zero-length start: done high in cycle 1; busy never asserts.
- Throughput is one chunk per cycle, with no bubbles between rows.

## Test plan
- vec_len=1, row_num=1, all bases 0, PE model result 0x5: rd addrs 0/0 in cycle 1; pe_ctl=2'b11 in cycle 2; out_wr addr 0, data 0x5 in cycle 3; done in cycle 4.
- vec_len=3, row_num=2, neuron_base=0x10, weight_base=0x20, out_base=0x40:
  - neuron addrs 10,11,12,10,11,12 and weight addrs 20..25 in cycles 1-6.
  - pe_ctl 01,00,10,01,00,10 in cycles 2-7.
  - Writes to 0x40 in cycle 5 and 0x41 in cycle 8; done in cycle 9.
- start pulsed again in cycle 3 of the previous job: ignored. Address sequence and done timing are unchanged; no second job runs.
- vec_len=0 with row_num=4: done in cycle 1, no rd_en, busy stays 0. Then a valid start runs normally.
- rst asserted in cycle 4 of the vec_len=3/row_num=2 job: all outputs 0 that cycle and no further writes. A fresh start then replays the sequence from weight_base.
- Wrap: weight_base=0xFE, neuron_base=0xFF, vec_len=4, row_num=1: weight addrs FE,FF,00,01; neuron addrs FF,00,01,02.
